// File: rtl/lat_dp_ram.sv
// rtl/lat_dp_ram.sv - dual-port RAM model with per-port response latency (optional stalls: LAT_DP_RAM_STALL_EN)
module lat_dp_ram #(
  parameter int          ADDR_WIDTH        = 22,
  parameter int          INSTR_RDATA_WIDTH = 128,
  parameter int          INSTR_LATENCY     = 1,
  parameter int          DATA_LATENCY      = 1,
  parameter logic [15:0] STALL_SEED        = 16'hACE1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         instr_req_i,
  input  logic [ADDR_WIDTH-1:0]        instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o,
  input  logic                         data_req_i,
  input  logic [ADDR_WIDTH-1:0]        data_addr_i,
  input  logic                         data_we_i,
  input  logic [3:0]                   data_be_i,
  input  logic [31:0]                  data_wdata_i,
  output logic                         data_gnt_o,
  output logic                         data_rvalid_o,
  output logic [31:0]                  data_rdata_o
);

  localparam int WORD_AW     = ADDR_WIDTH - 2;
  localparam int DEPTH       = 2 ** WORD_AW;
  localparam int INSTR_WORDS = INSTR_RDATA_WIDTH / 32;

  // Word storage; never reset so the harness preload survives rst_i.
  logic [31:0] mem [DEPTH];

  logic instr_stall, data_stall;
  logic instr_xfer, data_xfer;

  logic [WORD_AW-1:0]           instr_base;
  logic [WORD_AW-1:0]           data_idx;
  logic [INSTR_RDATA_WIDTH-1:0] instr_block;
  logic [31:0]                  data_word;
  logic [31:0]                  wmask;

  logic [INSTR_LATENCY-1:0]                        instr_vpipe;
  logic [INSTR_LATENCY-1:0][INSTR_RDATA_WIDTH-1:0] instr_dpipe;
  logic [DATA_LATENCY-1:0]                         data_vpipe;
  logic [DATA_LATENCY-1:0][31:0]                   data_dpipe;

  // Byte-address low bits carry no information for word-organised ports.
  logic unused_bits;
  assign unused_bits = ^{instr_addr_i[1:0], data_addr_i[1:0], STALL_SEED};

`ifdef LAT_DP_RAM_STALL_EN
  logic [15:0] instr_lfsr, data_lfsr;

  // Free-running Fibonacci LFSRs (taps 16,14,13,11), one per port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_lfsr <= STALL_SEED;
      data_lfsr  <= STALL_SEED;
    end else begin
      instr_lfsr <= {instr_lfsr[14:0], instr_lfsr[15] ^ instr_lfsr[13] ^ instr_lfsr[12] ^ instr_lfsr[10]};
      data_lfsr  <= {data_lfsr[14:0],  data_lfsr[15]  ^ data_lfsr[13]  ^ data_lfsr[12]  ^ data_lfsr[10]};
    end
  end

  assign instr_stall = (instr_lfsr[1:0] == 2'b00);
  assign data_stall  = (data_lfsr[1:0] == 2'b00);
`else
  assign instr_stall = 1'b0;
  assign data_stall  = 1'b0;
`endif

  assign instr_gnt_o = instr_req_i & ~instr_stall;
  assign data_gnt_o  = data_req_i & ~data_stall;
  assign instr_xfer  = instr_req_i & instr_gnt_o;
  assign data_xfer   = data_req_i & data_gnt_o;

  // Fetch blocks are naturally aligned, so the block never straddles the array end.
  assign instr_base = instr_addr_i[ADDR_WIDTH-1:2] & ~WORD_AW'(INSTR_WORDS - 1);
  assign data_idx   = data_addr_i[ADDR_WIDTH-1:2];
  assign data_word  = mem[data_idx];
  assign wmask      = {{8{data_be_i[3]}}, {8{data_be_i[2]}}, {8{data_be_i[1]}}, {8{data_be_i[0]}}};

  // Gather the fetch block from the array as it stands before this edge's write.
  always_comb begin
    instr_block = '0;
    for (int i = 0; i < INSTR_WORDS; i++) begin
      instr_block[32*i +: 32] = mem[instr_base | WORD_AW'(i)];
    end
  end

  // Byte-masked write; reads at the same edge see the old word.
  always_ff @(posedge clk_i) begin
    if (data_xfer && data_we_i) begin
      mem[data_idx] <= (data_word & ~wmask) | (data_wdata_i & wmask);
    end
  end

  // Fetch response pipeline; data stages only move with a valid so the output holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_vpipe <= '0;
      instr_dpipe <= '0;
    end else begin
      instr_vpipe[0] <= instr_xfer;
      if (instr_xfer) instr_dpipe[0] <= instr_block;
      for (int i = 1; i < INSTR_LATENCY; i++) begin
        instr_vpipe[i] <= instr_vpipe[i-1];
        if (instr_vpipe[i-1]) instr_dpipe[i] <= instr_dpipe[i-1];
      end
    end
  end

  // Data response pipeline; writes return the pre-write word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_vpipe <= '0;
      data_dpipe <= '0;
    end else begin
      data_vpipe[0] <= data_xfer;
      if (data_xfer) data_dpipe[0] <= data_word;
      for (int i = 1; i < DATA_LATENCY; i++) begin
        data_vpipe[i] <= data_vpipe[i-1];
        if (data_vpipe[i-1]) data_dpipe[i] <= data_dpipe[i-1];
      end
    end
  end

  assign instr_rvalid_o = instr_vpipe[INSTR_LATENCY-1];
  assign instr_rdata_o  = instr_dpipe[INSTR_LATENCY-1];
  assign data_rvalid_o  = data_vpipe[DATA_LATENCY-1];
  assign data_rdata_o   = data_dpipe[DATA_LATENCY-1];

endmodule
